uart_rx_irq: RTL

//  Serial receive front-end of the CPU peripheral block. Oversamples uart_in,

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_sample_ctr.sv | 52 +++++
 rtl/uart_rx_irq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, frame
// width and a counter-width helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Ceiling log2 with a floor of one bit so a counter always has a width.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/uart_sample_ctr.sv
// Line synchroniser, falling-edge detector and bit-timing counter for the
// UART receiver. The counter is held at zero while restart is high.
module uart_sample_ctr
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic uart_in,
  input  logic restart,
  output logic line,
  output logic fall,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = clog2(CLKS_PER_BIT);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic [CW-1:0]          cnt;

  // Sync flops reset to the idle level so leaving reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], uart_in};
      prev <= line;
    end
  end

  assign line = sync[SYNC_STAGES-1];
  assign fall = prev & ~line;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || full_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign half_tick = (cnt == CW'(CLKS_PER_BIT / 2 - 1));
  assign full_tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_irq.sv
// UART receive front-end with interrupt level, LED mirror and sticky flags.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err output.
module uart_rx_irq
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  input  logic       rd_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       int0,
  output logic       overrun,
  output logic       frame_err,
  output logic [7:0] leds
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  state_t                 state, next_state;
  logic [DATA_BITS-1:0]   shreg;
  logic [2:0]             bit_idx;
  logic                   line, fall, half_tick, full_tick;
  logic                   restart, sample_bit, stop_ok, stop_bad, byte_done;
`ifdef UART_RX_PARITY_EN
  logic                   par_sample, par_bad, par_fail;
`endif

  uart_sample_ctr #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sample_ctr (
    .clk      (clk),
    .rst      (rst),
    .uart_in  (uart_in),
    .restart  (restart),
    .line     (line),
    .fall     (fall),
    .half_tick(half_tick),
    .full_tick(full_tick)
  );

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    sample_bit = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_sample = 1'b0;
`endif
    case (state)
      IDLE: begin
        restart = 1'b1;
        if (fall) next_state = START;
      end
      // Re-check the line at mid start bit so short glitches are dropped.
      START: begin
        if (half_tick) begin
          if (!line) begin
            next_state = DATA;
            restart    = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (full_tick) begin
          sample_bit = 1'b1;
          if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            next_state = PARITY;
`else
            next_state = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (full_tick) begin
          par_sample = 1'b1;
          next_state = STOP;
        end
      end
`endif
      STOP: begin
        if (full_tick) begin
          next_state = IDLE;
          stop_ok    = line;
          stop_bad   = ~line;
        end
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign par_bad   = ^{shreg, line};
  assign byte_done = stop_ok & ~par_fail;
`else
  assign byte_done = stop_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      state <= next_state;
      if (state == START) bit_idx <= '0;
      if (sample_bit) begin
        shreg   <= {line, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // A completing byte takes priority over a same-cycle read, without flagging overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd_en) begin
        overrun   <= 1'b0;
        frame_err <= 1'b0;
        rx_valid  <= 1'b0;
      end
      if (byte_done) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
        if (rx_valid && !rd_en) overrun <= 1'b1;
      end
      if (stop_bad) frame_err <= 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_fail   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == START) par_fail <= 1'b0;
      if (rd_en) parity_err <= 1'b0;
      if (par_sample) begin
        par_fail <= par_bad;
        if (par_bad) parity_err <= 1'b1;
      end
    end
  end
`endif

  assign int0 = rx_valid;
  assign leds = rx_data;

endmodule
